escanear_movimientos: RTL and testbench
=======================================

ESCANEAR_MOVIMIENTOS -- requirements
Module: escanear_movimientos

Interface
REQ-001 Parameter: VALOR_VACIO, default 0, cell value that denotes an empty tile.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 iniciar  input  1  start request; sampled only in state INACTIVO.
REQ-006 matriz_entrada  input  int [4][4]  board; [fila][columna], fila 0 = top, columna 0 = left.
REQ-007 mov_izq, mov_der, mov_arr, mov_aba  output  int each  1 = move in that direction changes the board, 0 = not.
REQ-008 listo  output  1  one-cycle pulse; new mov_* values valid.
REQ-009 ocupado  output  1  high while a scan is in progress.

Function
REQ-010 The FSM SHALL have states INACTIVO, CAPTURA, ESCANEO, FIN.
REQ-011 INACTIVO -> CAPTURA SHALL occur on the edge where iniciar=1; iniciar=0 stays INACTIVO.
REQ-012 CAPTURA SHALL register all 16 cells of matriz_entrada into an internal copy, clear the four accumulators, clear a 4-bit cell counter, then go to ESCANEO.
REQ-013 ESCANEO SHALL evaluate one cell per cycle, index = counter, fila = counter[3:2], columna = counter[1:0], counter 0..15.
REQ-014 Cell c at (f,k) with neighbour n SHALL set a direction accumulator when c != VALOR_VACIO and (n == VALOR_VACIO or n == c), using the captured copy only.
REQ-015 Neighbours: izq uses (f,k-1) only if k>0; der uses (f,k+1) only if k<3; arr uses (f-1,k) only if f>0; aba uses (f+1,k) only if f<3; out-of-board neighbours never set a flag.
REQ-016 Comparison SHALL be on the full 32-bit signed value; no saturation or truncation.
REQ-017 Accumulators SHALL be sticky OR within a scan.
REQ-018 ESCANEO with counter=15 SHALL go to FIN after evaluating cell 15; the counter SHALL not wrap into a 17th evaluation.
REQ-019 FIN SHALL copy accumulators to mov_* (value 1 or 0), assert listo for exactly one cycle, and return to INACTIVO.
REQ-020 Latency: iniciar sampled at edge N -> mov_* updated and listo=1 after edge N+18, listo=0 after edge N+19.
REQ-021 ocupado SHALL be 1 in CAPTURA, ESCANEO and FIN, and 0 in INACTIVO.
REQ-022 iniciar while ocupado=1 SHALL be ignored and not queued; iniciar=1 in the cycle listo=1 SHALL start a new scan.
REQ-023 matriz_entrada changes after the CAPTURA edge SHALL not affect the current result.
REQ-024 mov_* SHALL hold their value between listo pulses.

Reset
REQ-025 rst=1 SHALL force, asynchronously: state INACTIVO, counter 0, accumulators 0, listo=0, ocupado=0.
REQ-026 mov_izq, mov_der, mov_arr and mov_aba SHALL reset to 1, so downstream loss detection does not fire before the first scan.
REQ-027 rst asserted mid-scan SHALL abort the scan with no listo pulse; the next iniciar after release SHALL start from CAPTURA.

Verification
REQ-028 rst pulse at any time -> mov_*=1,1,1,1; listo=0; ocupado=0 in the same cycle.
REQ-029 All-zero board plus iniciar at edge N -> listo=1 after edge N+18; mov_izq/der/arr/aba=0,0,0,0; ocupado high for 18 cycles.
REQ-030 Only [0][0]=2 -> izq=0, der=1, arr=0, aba=1.
REQ-031 Full checkerboard 2/4, no equal neighbours -> all four mov_*=0; same board with [3][2]=[3][3]=16 -> izq=1, der=1, arr=0, aba=0.
REQ-032 iniciar pulsed at N+5, and board changed to all-zero at N+3, during a scan of the [0][0]=2 board -> single listo at N+18 with the REQ-030 result; no second scan.
REQ-033 rst at N+10 during a scan -> no listo; mov_*=1; new iniciar after release -> correct result 18 cycles later.

Source files
------------

// File: rtl/escanear_movimientos.sv
// Scans a captured 4x4 board one cell per cycle and reports, per direction,
// whether a slide/merge move in that direction would change the board.
module escanear_movimientos #(
   parameter int VALOR_VACIO = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               iniciar,
   input  logic signed [31:0] matriz_entrada [4][4],
   output logic signed [31:0] mov_izq,
   output logic signed [31:0] mov_der,
   output logic signed [31:0] mov_arr,
   output logic signed [31:0] mov_aba,
   output logic               listo,
   output logic               ocupado
);

   typedef enum logic [1:0] {
      INACTIVO = 2'd0,
      CAPTURA  = 2'd1,
      ESCANEO  = 2'd2,
      FIN      = 2'd3
   } estado_t;

   localparam logic [3:0] ULTIMA_CELDA = 4'd15;

   estado_t            estado;
   estado_t            estado_sig;
   logic               ultima;

   logic signed [31:0] copia [4][4];
   logic [3:0]         contador;
   logic [1:0]         fila;
   logic [1:0]         columna;
   logic signed [31:0] celda;

   logic               acc_izq, acc_der, acc_arr, acc_aba;
   logic               hit_izq, hit_der, hit_arr, hit_aba;

   // A tile can move toward a neighbour that is empty or that it can merge with.
   function automatic logic puede_mover(input logic signed [31:0] c,
                                        input logic signed [31:0] n);
      return (c != VALOR_VACIO) && ((n == VALOR_VACIO) || (n == c));
   endfunction

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) estado <= INACTIVO;
      else     estado <= estado_sig;
   end

   assign ultima = (contador == ULTIMA_CELDA);

   // NOTE: every output of a combinational block gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      estado_sig = estado;
      ocupado    = 1'b1;
      unique case (estado)
         INACTIVO: begin
            ocupado = 1'b0;
            if (iniciar) estado_sig = CAPTURA;
         end
         CAPTURA:  estado_sig = ESCANEO;
         ESCANEO:  if (ultima) estado_sig = FIN;
         FIN:      estado_sig = INACTIVO;
         default:  estado_sig = INACTIVO;
      endcase
   end

   // ---------------------------------------------------------------- board copy
   // NOTE: the captured board is plain storage that is always rewritten in
   // CAPTURA before use, so it carries no reset.
   always_ff @(posedge clk) begin
      if (estado == CAPTURA) copia <= matriz_entrada;
   end

   // ---------------------------------------------------------------- cell evaluation
   assign fila    = contador[3:2];
   assign columna = contador[1:0];
   assign celda   = copia[fila][columna];

   always_comb begin
      hit_izq = 1'b0;
      hit_der = 1'b0;
      hit_arr = 1'b0;
      hit_aba = 1'b0;
      // Out-of-board neighbours never contribute.
      if (columna != 2'd0) hit_izq = puede_mover(celda, copia[fila][columna - 2'd1]);
      if (columna != 2'd3) hit_der = puede_mover(celda, copia[fila][columna + 2'd1]);
      if (fila    != 2'd0) hit_arr = puede_mover(celda, copia[fila - 2'd1][columna]);
      if (fila    != 2'd3) hit_aba = puede_mover(celda, copia[fila + 2'd1][columna]);
   end

   // ---------------------------------------------------------------- counter and accumulators
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         contador <= '0;
         acc_izq  <= 1'b0;
         acc_der  <= 1'b0;
         acc_arr  <= 1'b0;
         acc_aba  <= 1'b0;
      end else begin
         unique case (estado)
            CAPTURA: begin
               contador <= '0;
               acc_izq  <= 1'b0;
               acc_der  <= 1'b0;
               acc_arr  <= 1'b0;
               acc_aba  <= 1'b0;
            end
            ESCANEO: begin
               acc_izq <= acc_izq | hit_izq;
               acc_der <= acc_der | hit_der;
               acc_arr <= acc_arr | hit_arr;
               acc_aba <= acc_aba | hit_aba;
               // Hold at the last cell instead of wrapping into a 17th evaluation.
               if (!ultima) contador <= contador + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- results
   // Moves reset to "possible" so loss detection stays quiet until the first scan.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mov_izq <= 32'sd1;
         mov_der <= 32'sd1;
         mov_arr <= 32'sd1;
         mov_aba <= 32'sd1;
         listo   <= 1'b0;
      end else begin
         listo <= 1'b0;
         if (estado == FIN) begin
            mov_izq <= {31'd0, acc_izq};
            mov_der <= {31'd0, acc_der};
            mov_arr <= {31'd0, acc_arr};
            mov_aba <= {31'd0, acc_aba};
            listo   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_escanear_movimientos.sv
// Self-checking bench for escanear_movimientos: directed cases plus random
// boards checked against a slide-and-merge reference model.
module tb_escanear_movimientos;

   typedef logic signed [31:0] val_t;
   typedef val_t tablero_t [4][4];
   typedef val_t linea_t [4];
   typedef struct packed { logic izq, der, arr, aba; } movs_t;

   localparam val_t VACIO = 32'sd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        iniciar;
   tablero_t    matriz;
   val_t        mov_izq, mov_der, mov_arr, mov_aba;
   logic        listo, ocupado;

   int vectors    = 0;
   int miscompares = 0;

   escanear_movimientos #(.VALOR_VACIO(0)) dut (
      .clk            (clk),
      .rst            (rst),
      .iniciar        (iniciar),
      .matriz_entrada (matriz),
      .mov_izq        (mov_izq),
      .mov_der        (mov_der),
      .mov_arr        (mov_arr),
      .mov_aba        (mov_aba),
      .listo          (listo),
      .ocupado        (ocupado)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_movs(input string tag, input movs_t e);
      check({tag, "_izq"}, mov_izq, {31'd0, e.izq});
      check({tag, "_der"}, mov_der, {31'd0, e.der});
      check({tag, "_arr"}, mov_arr, {31'd0, e.arr});
      check({tag, "_aba"}, mov_aba, {31'd0, e.aba});
   endtask

   // Reference: a move changes the board iff sliding+merging the line toward
   // index 0 yields something different from the original line.
   function automatic logic linea_cambia(input linea_t l);
      val_t q[$];
      linea_t r;
      int n;
      int i;
      foreach (l[k]) if (l[k] != VACIO) q.push_back(l[k]);
      n = 0;
      i = 0;
      while (i < q.size()) begin
         if (i + 1 < q.size() && q[i] == q[i+1]) begin
            r[n] = q[i] + q[i+1];
            i += 2;
         end else begin
            r[n] = q[i];
            i += 1;
         end
         n++;
      end
      for (int k = n; k < 4; k++) r[k] = VACIO;
      return r != l;
   endfunction

   function automatic movs_t modelo(input tablero_t b);
      movs_t m;
      linea_t l;
      m = '0;
      for (int x = 0; x < 4; x++) begin
         for (int k = 0; k < 4; k++) l[k] = b[x][k];
         m.izq |= linea_cambia(l);
         for (int k = 0; k < 4; k++) l[k] = b[x][3-k];
         m.der |= linea_cambia(l);
         for (int k = 0; k < 4; k++) l[k] = b[k][x];
         m.arr |= linea_cambia(l);
         for (int k = 0; k < 4; k++) l[k] = b[3-k][x];
         m.aba |= linea_cambia(l);
      end
      return m;
   endfunction

   function automatic tablero_t tablero_aleatorio();
      tablero_t b;
      val_t pool [8];
      pool = '{32'sd0, 32'sd0, 32'sd2, 32'sd2, 32'sd4, 32'sd16, -32'sd7, 32'sd1000};
      foreach (b[f, k]) b[f][k] = pool[$urandom_range(0, 7)];
      return b;
   endfunction

   function automatic tablero_t tablero_vacio();
      tablero_t b;
      foreach (b[f, k]) b[f][k] = VACIO;
      return b;
   endfunction

   // Starts a scan at the next edge (N) and checks ocupado/listo through N+18.
   // Returns right after edge N+18, with listo expected high.
   task automatic escanear(input tablero_t b, input movs_t e, input string tag);
      matriz  = b;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      for (int i = 0; i < 18; i++) begin
         check({tag, "_ocupado"}, {31'd0, ocupado}, 32'd1);
         check({tag, "_listo_bajo"}, {31'd0, listo}, 32'd0);
         tick();
      end
      check({tag, "_listo"}, {31'd0, listo}, 32'd1);
      check_movs(tag, e);
   endtask

   task automatic fin_pulso(input string tag);
      tick();
      check({tag, "_listo_fin"}, {31'd0, listo}, 32'd0);
      check({tag, "_ocupado_fin"}, {31'd0, ocupado}, 32'd0);
   endtask

   initial begin
      tablero_t b;
      movs_t    e;
      int       pulsos;

      rst     = 1'b1;
      iniciar = 1'b0;
      matriz  = tablero_vacio();
      #1;
      check_movs("reset", 4'b1111);
      check("reset_listo", {31'd0, listo}, 32'd0);
      check("reset_ocupado", {31'd0, ocupado}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("idle_ocupado", {31'd0, ocupado}, 32'd0);

      // All-zero board: nothing can move.
      escanear(tablero_vacio(), 4'b0000, "vacio");
      fin_pulso("vacio");

      // Single tile in the top-left corner.
      b = tablero_vacio();
      b[0][0] = 32'sd2;
      escanear(b, 4'b0101, "esquina");
      fin_pulso("esquina");

      // mov_* hold between pulses even while the board input changes.
      matriz = tablero_aleatorio();
      repeat (4) tick();
      check_movs("retencion", 4'b0101);

      // Checkerboard of 2/4 with no equal neighbours.
      foreach (b[f, k]) b[f][k] = ((f + k) % 2 == 1) ? 32'sd4 : 32'sd2;
      escanear(b, 4'b0000, "ajedrez");
      fin_pulso("ajedrez");
      b[3][2] = 32'sd16;
      b[3][3] = 32'sd16;
      escanear(b, 4'b1100, "ajedrez16");
      fin_pulso("ajedrez16");

      // Board changes after capture and iniciar during the scan are ignored.
      b = tablero_vacio();
      b[0][0] = 32'sd2;
      matriz  = b;
      iniciar = 1'b1;
      tick();                       // edge N
      iniciar = 1'b0;
      tick();                       // N+1: capture
      tick();                       // N+2
      matriz = tablero_vacio();
      tick();                       // N+3
      tick();                       // N+4
      iniciar = 1'b1;
      tick();                       // N+5
      iniciar = 1'b0;
      pulsos = 0;
      for (int i = 6; i <= 18; i++) begin
         tick();
         if (listo) pulsos++;
      end
      check("ignora_listo", {31'd0, listo}, 32'd1);
      check("ignora_pulsos", pulsos, 32'd1);
      check_movs("ignora", 4'b0101);
      pulsos = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (listo) pulsos++;
      end
      check("sin_segundo_escaneo", pulsos, 32'd0);
      check("sin_segundo_ocupado", {31'd0, ocupado}, 32'd0);

      // Reset in the middle of a scan aborts it with no listo.
      matriz  = tablero_vacio();
      iniciar = 1'b1;
      tick();                       // edge N
      iniciar = 1'b0;
      repeat (10) tick();           // up to N+10
      rst = 1'b1;
      #1;
      check_movs("abort", 4'b1111);
      check("abort_listo", {31'd0, listo}, 32'd0);
      check("abort_ocupado", {31'd0, ocupado}, 32'd0);
      tick();
      rst = 1'b0;
      pulsos = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (listo) pulsos++;
      end
      check("abort_sin_listo", pulsos, 32'd0);
      check_movs("abort_retiene", 4'b1111);
      b = tablero_aleatorio();
      escanear(b, modelo(b), "tras_abort");
      fin_pulso("tras_abort");

      // iniciar during the listo cycle starts the next scan back-to-back.
      b = tablero_aleatorio();
      escanear(b, modelo(b), "seguido_a");
      b = tablero_aleatorio();
      escanear(b, modelo(b), "seguido_b");
      fin_pulso("seguido_b");

      // Random boards against the reference model.
      for (int t = 0; t < 20; t++) begin
         b = tablero_aleatorio();
         e = modelo(b);
         escanear(b, e, $sformatf("azar%0d", t));
         fin_pulso($sformatf("azar%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
